// File: rtl/ascon_pkg.sv
// ---------------------------------------------------------------------------
// ascon_pkg
// Shared definitions for the Ascon-128 block packer:
//   PAD_BYTE        - first byte of the Ascon 10* padding
//   RATE_BYTES_DEF  - default rate in bytes (8 = Ascon-128)
//   seg_e           - segment type carried with each block (AD / PT)
//   pk_state_e      - packer control state (FILL / EMIT)
// ---------------------------------------------------------------------------
package ascon_pkg;

    localparam logic [7:0] PAD_BYTE       = 8'h80;
    localparam int         RATE_BYTES_DEF = 8;

    typedef enum logic {
        SEG_AD = 1'b0,
        SEG_PT = 1'b1
    } seg_e;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } pk_state_e;

endpackage

// File: rtl/ascon_pad_mask.sv
// ---------------------------------------------------------------------------
// ascon_pad_mask
// Combinational 10* padding of a rate-sized block. Slot 0 is the MSB byte.
// Slots below i_pos pass through, slot i_pos becomes PAD_BYTE and every
// slot above it is zeroed.
// Ports:
//   i_block  in  8*RATE_BYTES  block holding the message bytes
//   i_pos    in  CW            slot that receives the pad byte
//   o_block  out 8*RATE_BYTES  padded block
// ---------------------------------------------------------------------------
module ascon_pad_mask
    import ascon_pkg::*;
#(
    parameter  int RATE_BYTES = RATE_BYTES_DEF,
    localparam int CW         = $clog2(RATE_BYTES + 1)
) (
    input  logic [8*RATE_BYTES-1:0] i_block,
    input  logic [CW-1:0]           i_pos,
    output logic [8*RATE_BYTES-1:0] o_block
);

    always_comb begin
        o_block = '0;
        for (int i = 0; i < RATE_BYTES; i++) begin
            if (CW'(i) < i_pos) begin
                o_block[8*(RATE_BYTES-i)-1 -: 8] = i_block[8*(RATE_BYTES-i)-1 -: 8];
            end else if (CW'(i) == i_pos) begin
                o_block[8*(RATE_BYTES-i)-1 -: 8] = PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/ascon_block_packer.sv
// ---------------------------------------------------------------------------
// ascon_block_packer
// Packs a byte-serial AD / PT stream into rate-sized, 10*-padded blocks for
// the Ascon-128 encrypt datapath. One block per output handshake, tagged with
// segment type, message-byte count and a last flag (the block carrying pad).
//
// Optional feature (macro ASCON_PACKER_ERR_EN): adds a sticky 'err' output
// that flags protocol errors (type change mid-block, misplaced s_empty).
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   s_valid   in   input beat valid
//   s_ready   out  input beat accepted when s_valid && s_ready
//   s_data    in   input byte
//   s_type    in   segment type (0 = AD, 1 = PT)
//   s_last    in   final beat of the segment
//   s_empty   in   beat carries no byte
//   m_valid   out  output block valid
//   m_ready   in   downstream accepts the block
//   m_block   out  padded block, first byte in the MSB byte
//   m_type    out  segment type of the block
//   m_nbytes  out  message bytes in the block (0..RATE_BYTES)
//   m_last    out  final block of the segment
//   err       out  sticky protocol error (ASCON_PACKER_ERR_EN only)
// ---------------------------------------------------------------------------
module ascon_block_packer
    import ascon_pkg::*;
#(
    parameter  int RATE_BYTES = RATE_BYTES_DEF,
    localparam int CW         = $clog2(RATE_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [7:0]              s_data,
    input  logic                    s_type,
    input  logic                    s_last,
    input  logic                    s_empty,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [8*RATE_BYTES-1:0] m_block,
    output logic                    m_type,
    output logic [CW-1:0]           m_nbytes,
    output logic                    m_last
`ifdef ASCON_PACKER_ERR_EN
    ,
    output logic                    err
`endif
);

    localparam int            BW        = 8 * RATE_BYTES;
    localparam logic [CW-1:0] LAST_SLOT = CW'(RATE_BYTES - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(RATE_BYTES);

    pk_state_e     r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [BW-1:0] r_buf, w_buf_nxt;
    seg_e          r_type, w_type_nxt;
    logic          r_pad_pending, w_pad_nxt;
    logic [CW-1:0] r_nbytes, w_nbytes_nxt;
    logic          r_last, w_last_nxt;

    logic          w_accept;
    logic [BW-1:0] w_wr_buf;
    logic [CW-1:0] w_pad_pos;
    logic [BW-1:0] w_padded;

    // Combinational reset term keeps s_ready low for the whole reset window.
    assign s_ready  = rst_n && (r_state == FILL);
    assign w_accept = s_valid && s_ready;

    assign m_valid  = (r_state == EMIT);
    assign m_block  = r_buf;
    assign m_type   = r_type;
    assign m_nbytes = r_nbytes;
    assign m_last   = r_last;

    // Buffer with the incoming byte dropped into slot cnt (none on s_empty).
    always_comb begin
        w_wr_buf = r_buf;
        if (!s_empty) begin
            for (int i = 0; i < RATE_BYTES; i++) begin
                if (CW'(i) == r_cnt) begin
                    w_wr_buf[8*(RATE_BYTES-i)-1 -: 8] = s_data;
                end
            end
        end
    end

    // Pad slot: 0 for the standalone pad block emitted from EMIT, cnt for an
    // empty beat, cnt+1 behind a freshly written short-last byte.
    always_comb begin
        w_pad_pos = '0;
        if (r_state == FILL) begin
            w_pad_pos = s_empty ? r_cnt : (r_cnt + CW'(1));
        end
    end

    ascon_pad_mask #(
        .RATE_BYTES (RATE_BYTES)
    ) u_pad_mask (
        .i_block (w_wr_buf),
        .i_pos   (w_pad_pos),
        .o_block (w_padded)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_buf_nxt    = r_buf;
        w_type_nxt   = r_type;
        w_pad_nxt    = r_pad_pending;
        w_nbytes_nxt = r_nbytes;
        w_last_nxt   = r_last;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    if (r_cnt == '0) begin
                        w_type_nxt = seg_e'(s_type);
                    end
                    if (s_empty) begin
                        // Empty beat closes the block whatever cnt or s_last say.
                        w_buf_nxt    = w_padded;
                        w_nbytes_nxt = r_cnt;
                        w_last_nxt   = 1'b1;
                        w_state_nxt  = EMIT;
                    end else if (r_cnt == LAST_SLOT) begin
                        // Full block cannot hold the pad; defer it to a block of its own.
                        w_buf_nxt    = w_wr_buf;
                        w_nbytes_nxt = FULL_CNT;
                        w_last_nxt   = 1'b0;
                        w_pad_nxt    = s_last;
                        w_state_nxt  = EMIT;
                    end else if (s_last) begin
                        w_buf_nxt    = w_padded;
                        w_nbytes_nxt = r_cnt + CW'(1);
                        w_last_nxt   = 1'b1;
                        w_state_nxt  = EMIT;
                    end else begin
                        w_buf_nxt = w_wr_buf;
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            EMIT: begin
                if (m_ready) begin
                    if (r_pad_pending) begin
                        w_buf_nxt    = w_padded;
                        w_nbytes_nxt = '0;
                        w_last_nxt   = 1'b1;
                        w_pad_nxt    = 1'b0;
                    end else begin
                        w_state_nxt  = FILL;
                        w_cnt_nxt    = '0;
                        w_buf_nxt    = '0;
                        w_nbytes_nxt = '0;
                        w_last_nxt   = 1'b0;
                    end
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= FILL;
            r_cnt         <= '0;
            r_buf         <= '0;
            r_type        <= SEG_AD;
            r_pad_pending <= 1'b0;
            r_nbytes      <= '0;
            r_last        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_buf         <= w_buf_nxt;
            r_type        <= w_type_nxt;
            r_pad_pending <= w_pad_nxt;
            r_nbytes      <= w_nbytes_nxt;
            r_last        <= w_last_nxt;
        end
    end

`ifdef ASCON_PACKER_ERR_EN
    logic r_err;
    logic w_proto_err;

    assign w_proto_err = w_accept &&
                         ((s_empty && ((r_cnt != '0) || !s_last)) ||
                          ((r_cnt != '0) && (s_type != logic'(r_type))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | w_proto_err;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_ascon_block_packer.sv
// ---------------------------------------------------------------------------
// tb_ascon_block_packer
// Self-checking bench for ascon_block_packer (RATE_BYTES = 8). Segments are
// queued as beats, a list-level model derives the expected blocks, and the
// DUT output stream is compared block by block. Build with
// +define+ASCON_PACKER_ERR_EN to also exercise the err output.
// ---------------------------------------------------------------------------
module tb_ascon_block_packer;

    localparam int RB = 8;
    localparam int CW = $clog2(RB + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            s_valid;
    logic            s_ready;
    logic [7:0]      s_data;
    logic            s_type;
    logic            s_last;
    logic            s_empty;
    logic            m_valid;
    logic            m_ready;
    logic [8*RB-1:0] m_block;
    logic            m_type;
    logic [CW-1:0]   m_nbytes;
    logic            m_last;
`ifdef ASCON_PACKER_ERR_EN
    logic            err;
`endif

    always #5 clk = ~clk;

    ascon_block_packer #(.RATE_BYTES(RB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_type   (s_type),
        .s_last   (s_last),
        .s_empty  (s_empty),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_block  (m_block),
        .m_type   (m_type),
        .m_nbytes (m_nbytes),
        .m_last   (m_last)
`ifdef ASCON_PACKER_ERR_EN
        ,
        .err      (err)
`endif
    );

    typedef struct {
        logic [7:0] d;
        logic       t;
        logic       l;
        logic       e;
    } beat_t;

    typedef struct {
        logic [63:0] blk;
        logic        t;
        int          nb;
        logic        l;
    } blk_t;

    beat_t      beats[$];
    blk_t       expq[$];
    logic [7:0] acc[$];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: bytes of the current block held in acc, padded 10* when closed.
    task automatic push_blk(input logic t, input logic l);
        blk_t x;
        x.blk = '0;
        for (int k = 0; k < acc.size(); k++) begin
            x.blk |= {56'h0, acc[k]} << (8 * (RB - 1 - k));
        end
        if (acc.size() < RB) x.blk |= 64'h80 << (8 * (RB - 1 - acc.size()));
        x.t  = t;
        x.nb = acc.size();
        x.l  = l;
        expq.push_back(x);
        acc.delete();
    endtask

    task automatic build_model();
        logic bt;
        bt = 1'b0;
        acc.delete();
        foreach (beats[i]) begin
            if (acc.size() == 0) bt = beats[i].t;
            if (beats[i].e) begin
                push_blk(bt, 1'b1);
            end else begin
                acc.push_back(beats[i].d);
                if (acc.size() == RB) begin
                    push_blk(bt, 1'b0);
                    if (beats[i].l) push_blk(bt, 1'b1);
                end else if (beats[i].l) begin
                    push_blk(bt, 1'b1);
                end
            end
        end
    endtask

    task automatic add_bytes(input int n, input logic [7:0] start, input logic t);
        for (int k = 0; k < n; k++) begin
            beats.push_back('{d: start + 8'(k), t: t, l: (k == n - 1), e: 1'b0});
        end
    endtask

    // mode 0: all handshakes immediate; 1: random s_valid/m_ready;
    // 2: m_ready low for the first 5 valid cycles
    task automatic run(input int mode);
        int          idx, cyc, vcnt, fill;
        logic        held, exp_mv, rdy;
        blk_t        sv, ex;
        idx = 0; cyc = 0; vcnt = 0; fill = 0;
        held = 1'b0; exp_mv = 1'b0;
        sv = '{blk: '0, t: 1'b0, nb: 0, l: 1'b0};
        build_model();
        while ((idx < beats.size() || expq.size() > 0) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            chk("ready_vs_valid", 64'(s_ready), 64'(!m_valid));
            if (exp_mv) chk("latency", 64'(m_valid), 64'd1);
            exp_mv = 1'b0;
            if (held) begin
                chk("hold_valid",  64'(m_valid), 64'd1);
                chk("hold_block",  m_block, sv.blk);
                chk("hold_nbytes", 64'(m_nbytes), 64'(sv.nb));
                chk("hold_last",   64'(m_last), 64'(sv.l));
                chk("hold_type",   64'(m_type), 64'(sv.t));
            end
            if (mode == 1)      rdy = 1'($urandom_range(0, 1));
            else if (mode == 2) rdy = m_valid ? (vcnt >= 5) : 1'b1;
            else                rdy = 1'b1;
            if (m_valid) vcnt++;
            m_ready = rdy;
            held = 1'b0;
            if (m_valid && rdy) begin
                if (expq.size() == 0) begin
                    chk("unexpected_block", m_block, 64'hx);
                end else begin
                    ex = expq.pop_front();
                    chk("block",  m_block, ex.blk);
                    chk("nbytes", 64'(m_nbytes), 64'(ex.nb));
                    chk("last",   64'(m_last), 64'(ex.l));
                    chk("type",   64'(m_type), 64'(ex.t));
                end
            end else if (m_valid) begin
                held = 1'b1;
                sv = '{blk: m_block, t: m_type, nb: int'(m_nbytes), l: m_last};
            end
            if (idx < beats.size()) begin
                s_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                s_data  = beats[idx].d;
                s_type  = beats[idx].t;
                s_last  = beats[idx].l;
                s_empty = beats[idx].e;
                if (s_valid && s_ready) begin
                    if (beats[idx].e || beats[idx].l || fill == RB - 1) begin
                        exp_mv = 1'b1;
                        fill = 0;
                    end else begin
                        fill++;
                    end
                    idx++;
                end
            end else begin
                s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_empty = 1'b0;
            end
        end
        chk("timeout", 64'(cyc < 400), 64'd1);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; s_empty = 1'b0; m_ready = 1'b0;
        chk("idle_after", 64'(m_valid), 64'd0);
        beats.delete();
        expq.delete();
    endtask

    initial begin
        logic [7:0] rb;
        int         len;
        logic       rt;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_type = 1'b0;
        s_last = 1'b0; s_empty = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready",  64'(s_ready), 64'd0);
        chk("rst_m_valid",  64'(m_valid), 64'd0);
        chk("rst_m_block",  m_block, 64'd0);
        chk("rst_m_nbytes", 64'(m_nbytes), 64'd0);
        chk("rst_m_last",   64'(m_last), 64'd0);
        chk("rst_m_type",   64'(m_type), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", 64'(s_ready), 64'd1);

        // AD 00,01,02 short last
        add_bytes(3, 8'h00, 1'b0);
        run(0);
        // PT 00..07 aligned tail -> extra pad block
        add_bytes(8, 8'h00, 1'b1);
        run(0);
        // zero-length PT segment
        beats.push_back('{d: 8'h5A, t: 1'b1, l: 1'b1, e: 1'b1});
        run(0);
        // 11 PT bytes with 5-cycle stall on the first block
        add_bytes(11, 8'h10, 1'b1);
        run(2);

        // reset in the middle of a segment
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1; s_data = 8'(k); s_type = 1'b0; s_last = 1'b0; s_empty = 1'b0;
            @(negedge clk);
            chk("abort_no_valid", 64'(m_valid), 64'd0);
        end
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_s_ready", 64'(s_ready), 64'd0);
        chk("midrst_m_block", m_block, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b0;
        add_bytes(1, 8'hAA, 1'b0);
        run(0);
`ifdef ASCON_PACKER_ERR_EN
        chk("err_clear", 64'(err), 64'd0);
`endif

        // type toggles at byte 3: block keeps AD type
        for (int k = 0; k < 5; k++) begin
            beats.push_back('{d: 8'h30 + 8'(k), t: (k >= 3), l: (k == 4), e: 1'b0});
        end
        run(0);
`ifdef ASCON_PACKER_ERR_EN
        chk("err_set", 64'(err), 64'd1);
        repeat (10) @(negedge clk);
        chk("err_sticky", 64'(err), 64'd1);
`endif

        // s_empty after 3 bytes, and s_empty without s_last at cnt==0
        add_bytes(3, 8'h40, 1'b0);
        beats[2].l = 1'b0;
        beats.push_back('{d: 8'hFF, t: 1'b0, l: 1'b1, e: 1'b1});
        beats.push_back('{d: 8'hEE, t: 1'b1, l: 1'b0, e: 1'b1});
        run(0);

        // randomized segments with random backpressure
        for (int s = 0; s < 30; s++) begin
            len = $urandom_range(0, 20);
            rt  = 1'($urandom_range(0, 1));
            if (len == 0) begin
                beats.push_back('{d: 8'h00, t: rt, l: 1'b1, e: 1'b1});
            end else begin
                for (int k = 0; k < len; k++) begin
                    rb = 8'($urandom_range(0, 255));
                    beats.push_back('{d: rb, t: rt, l: (k == len - 1), e: 1'b0});
                end
            end
            run(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
